route_request_sequencer: RTL
============================

Name: route_request_sequencer

Overview:
- Request-side counterpart to the per-route combinational interlock units in the ring interlock circuit.
- Collects route-set and cancel requests from the control panel for 8 routes (A..H).
- Drives each route's active line into the interlock network one candidate at a time, and waits until the interlock's per-route permit is stable before locking the route.
- Holds locked routes until a release arrives; rejects candidates whose permit drops.

Parameters:
N_ROUTES, 8, number of routes (bit 0 = A ... bit 7 = H)
CONFIRM_CYCLES, 3, consecutive cycles i_permit[k] must be high before route k locks (>=1)
ID_W, 3, width of route index outputs, equal to clog2(N_ROUTES)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req  input  N_ROUTES  per-route set request; a 1-cycle pulse is sufficient
i_cancel  input  N_ROUTES  per-route cancel of a pending or in-check request
i_release  input  N_ROUTES  per-route release of a locked route (train cleared)
i_permit  input  N_ROUTES  per-route permit from the interlock units (1 = no conflict)
o_route_set  output  N_ROUTES  route active lines to the interlock inputs (locked OR tentative)
o_locked  output  N_ROUTES  committed locked routes
o_busy  output  1  high when the FSM is not in IDLE
o_granted  output  1  1-cycle pulse when a route locks
o_rejected  output  1  1-cycle pulse when a candidate is rejected
o_event_id  output  ID_W  route index for o_granted/o_rejected; holds its last value otherwise

Behaviour:
- Reset, asynchronous and active-low, clears all of the following:
  - pending, locked and tentative registers
  - o_granted, o_rejected, o_event_id and the confirm counter
  - round-robin pointer set to 0; FSM set to IDLE
  - Effect: o_route_set=0, o_busy=0.
- Reset asserted mid-check drops the candidate immediately. No reject pulse is produced.
- Pending register, updated every edge: pending <= (pending | (i_req & ~locked)) & ~i_cancel, with the candidate bit cleared on grant, reject or abort.
  - Cancel wins over req on the same bit.
  - A request for an already-locked route is dropped.
- Locked register: bits clear on i_release; bits set on grant.
  - Release of a non-locked bit is ignored, including the current candidate.
- o_route_set = locked | tentative, registered; tentative has at most one bit set.
- FSM states:
  - IDLE: if pending != 0, select the first set bit k searching upward from the pointer (wrapping). Set tentative=1<<k and go to PROBE.
  - PROBE: a single settle cycle; the interlock sees the candidate now. Clear the counter and go to CONFIRM.
  - CONFIRM: sample i_permit[k] each cycle.
    - If high, increment the counter; when it reaches CONFIRM_CYCLES: locked[k]<=1, tentative<=0, clear pending[k], pulse o_granted, o_event_id<=k, pointer<=k+1 mod N, go to IDLE.
    - If low: tentative<=0, clear pending[k], pulse o_rejected, o_event_id<=k, pointer<=k+1, go to IDLE.
- Abort: i_cancel[k] in PROBE or CONFIRM takes precedence over permit and the count. It clears tentative and pending[k], sets pointer<=k+1 and returns to IDLE. No pulse.
- Timing: with req pulse at edge t in IDLE and permit high, tentative is visible after t+1, lock/o_granted after t+2+CONFIRM_CYCLES. For the default this is t+5.
- Candidate requests arriving again while in check are absorbed; no duplicate pending entry.
- i_permit of non-candidate routes is ignored. Locked routes are never revoked by permit; only release clears them.

Test Plan:
- Reset then req[2] pulse, i_permit=all 1 -> o_route_set=0x04 after 1 edge, o_granted with o_event_id=2 after 5 edges, o_locked=0x04 held.
- Lock route 0; then req[1] with i_permit[1] dropping to 0 in 2nd CONFIRM cycle -> o_rejected, o_event_id=1, o_route_set returns to 0x01, pending[1]=0.
- Simultaneous req=0x81, pointer=0, permits high -> route 0 granted first, then route 7. o_locked=0x81 after both grants; pointer=0 after 7.
- req[3] then i_cancel[3] during CONFIRM -> no pulse; tentative bit clears next edge; o_busy=0; o_locked unchanged.
- Lock route 5, then i_release[5] and i_req[5] same cycle -> lock clears and the request is dropped (o_locked=0, no new probe). A req[5] one cycle later re-locks.
- Drop i_rst_n during CONFIRM of route 4 with route 1 locked -> o_route_set=0, o_locked=0, no pulses asynchronously. Normal operation resumes after release of reset.

Source files
------------

// File: rtl/route_request_sequencer_if.sv
// Panel/interlock-facing bundle of the route request sequencer: request, cancel,
// release and permit inputs, plus route-active, locked and event-report outputs.
interface route_request_sequencer_if #(
  parameter int N_ROUTES = 8,
  parameter int ID_W     = 3
);
  logic [N_ROUTES-1:0] i_req;
  logic [N_ROUTES-1:0] i_cancel;
  logic [N_ROUTES-1:0] i_release;
  logic [N_ROUTES-1:0] i_permit;
  logic [N_ROUTES-1:0] o_route_set;
  logic [N_ROUTES-1:0] o_locked;
  logic                o_busy;
  logic                o_granted;
  logic                o_rejected;
  logic [ID_W-1:0]     o_event_id;

  modport master (
    output i_req, i_cancel, i_release, i_permit,
    input  o_route_set, o_locked, o_busy, o_granted, o_rejected, o_event_id
  );

  modport slave (
    input  i_req, i_cancel, i_release, i_permit,
    output o_route_set, o_locked, o_busy, o_granted, o_rejected, o_event_id
  );
endinterface

// File: rtl/route_request_sequencer.sv
// Queues route set requests, presents one candidate at a time to the interlock network,
// and locks it only after its permit has held for CONFIRM_CYCLES consecutive cycles.
module route_request_sequencer #(
  parameter int N_ROUTES       = 8,
  parameter int CONFIRM_CYCLES = 3,
  parameter int ID_W           = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  route_request_sequencer_if.slave bus
);
  localparam int              CNT_W    = $clog2(CONFIRM_CYCLES + 1);
  localparam int              SUM_W    = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_ROUTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROBE   = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  function automatic logic [N_ROUTES-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_ROUTES-1:0] v;
    v      = {N_ROUTES{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] idx);
    logic [ID_W-1:0] r;
    if (idx == ID_LAST) r = {ID_W{1'b0}};
    else                r = idx + ID_W'(1);
    return r;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [N_ROUTES-1:0] pending_r, locked_r, tentative_r, route_set_r;
  logic [N_ROUTES-1:0] pending_nxt_s, locked_nxt_s, tentative_nxt_s;
  logic [N_ROUTES-1:0] pool_s, cand_mask_s;
  logic [ID_W-1:0]     cand_r, ptr_r, event_id_r, pick_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic                granted_r, rejected_r, busy_r;
  logic                found_s, cand_cancel_s, cand_permit_s, cnt_done_s;
  logic                start_s, grant_s, reject_s, abort_s, retire_s;

  // A request cancelled on the same cycle it would be picked is never probed.
  assign pool_s        = pending_r & ~bus.i_cancel;
  assign cand_cancel_s = bus.i_cancel[cand_r];
  assign cand_permit_s = bus.i_permit[cand_r];
  assign cnt_done_s    = (cnt_r == CNT_LAST);
  assign cand_mask_s   = onehot(cand_r);
  assign retire_s      = grant_s | reject_s | abort_s;

  // Round-robin pick: first pending route at or above the pointer, wrapping.
  always_comb begin
    logic [SUM_W-1:0] sum_v;
    found_s = 1'b0;
    pick_s  = ptr_r;
    sum_v   = {SUM_W{1'b0}};
    for (int i = 0; i < N_ROUTES; i++) begin
      sum_v = {1'b0, ptr_r} + SUM_W'(i);
      if (sum_v >= SUM_W'(N_ROUTES)) sum_v = sum_v - SUM_W'(N_ROUTES);
      else                           sum_v = sum_v;
      if (!found_s && pool_s[sum_v[ID_W-1:0]]) begin
        found_s = 1'b1;
        pick_s  = sum_v[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next-state logic; cancel of the candidate outranks permit and count.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_nxt_s = ST_PROBE;
        else         state_nxt_s = ST_IDLE;
      end
      ST_PROBE: begin
        if (cand_cancel_s) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (cand_cancel_s || !cand_permit_s || cnt_done_s) state_nxt_s = ST_IDLE;
        else                                               state_nxt_s = ST_CONFIRM;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: start/grant/reject/abort events and the confirm counter.
  always_comb begin
    start_s   = 1'b0;
    grant_s   = 1'b0;
    reject_s  = 1'b0;
    abort_s   = 1'b0;
    cnt_nxt_s = cnt_r;
    case (state_r)
      ST_IDLE: start_s = found_s;
      ST_PROBE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        abort_s   = cand_cancel_s;
      end
      ST_CONFIRM: begin
        if (cand_cancel_s)       abort_s   = 1'b1;
        else if (!cand_permit_s) reject_s  = 1'b1;
        else if (cnt_done_s)     grant_s   = 1'b1;
        else                     cnt_nxt_s = cnt_r + CNT_W'(1);
      end
      default: cnt_nxt_s = {CNT_W{1'b0}};
    endcase
  end

  // Next values of the route bit-vectors.
  always_comb begin
    pending_nxt_s = ((pending_r | (bus.i_req & ~locked_r)) & ~bus.i_cancel)
                  & ~(retire_s ? cand_mask_s : {N_ROUTES{1'b0}});
    locked_nxt_s  = (locked_r & ~bus.i_release) | (grant_s ? cand_mask_s : {N_ROUTES{1'b0}});
    if (start_s)       tentative_nxt_s = onehot(pick_s);
    else if (retire_s) tentative_nxt_s = {N_ROUTES{1'b0}};
    else               tentative_nxt_s = tentative_r;
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_r   <= {N_ROUTES{1'b0}};
      locked_r    <= {N_ROUTES{1'b0}};
      tentative_r <= {N_ROUTES{1'b0}};
      route_set_r <= {N_ROUTES{1'b0}};
      cand_r      <= {ID_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
      event_id_r  <= {ID_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      granted_r   <= 1'b0;
      rejected_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      pending_r   <= pending_nxt_s;
      locked_r    <= locked_nxt_s;
      tentative_r <= tentative_nxt_s;
      route_set_r <= locked_nxt_s | tentative_nxt_s;
      cand_r      <= start_s ? pick_s : cand_r;
      ptr_r       <= retire_s ? next_id(cand_r) : ptr_r;
      event_id_r  <= (grant_s | reject_s) ? cand_r : event_id_r;
      cnt_r       <= cnt_nxt_s;
      granted_r   <= grant_s;
      rejected_r  <= reject_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.o_route_set = route_set_r;
  assign bus.o_locked    = locked_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_granted   = granted_r;
  assign bus.o_rejected  = rejected_r;
  assign bus.o_event_id  = event_id_r;
endmodule
